// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one byte at a time from four requesters to a UART transmitter.
// Optional: define UART_ARB_TIMEOUT_EN to abort a START the transmitter never acknowledges.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_50m,
  input  logic        clear,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic        arb_busy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  last_grant_q;
  logic [1:0]  grant_id_q;
  logic [3:0]  ack_q;
  logic [7:0]  tx_data_q;
  logic        tx_en_q;
  logic [1:0]  sel_d;
  logic        sel_valid_d;

  // Walk offsets 4..1 so the requester nearest after last_grant overwrites the others.
  always_comb begin
    logic [1:0] idx;
    sel_d       = last_grant_q;
    sel_valid_d = 1'b0;
    idx         = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = last_grant_q + 2'(i) + 2'd1;
      if (req[idx]) begin
        sel_d       = idx;
        sel_valid_d = 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;
  logic        timeout_err_q;
  logic        timeout_hit;

  assign timeout_hit = (to_cnt_q == TIMEOUT_LAST);
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_50m) begin
    if (clear) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      grant_id_q   <= 2'd0;
      ack_q        <= 4'd0;
      tx_data_q    <= 8'h00;
      tx_en_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q      <= 16'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      ack_q <= 4'd0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (sel_valid_d && !tx_busy) begin
            grant_id_q   <= sel_d;
            last_grant_q <= sel_d;
            tx_data_q    <= req_data[{sel_d, 3'b000} +: 8];
            tx_en_q      <= 1'b1;
            state_q      <= START;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q     <= 16'd0;
`endif
          end
        end
        START: begin
          // Only a high tx_busy sample means the transmitter has taken the byte.
          if (tx_busy) begin
            ack_q   <= 4'b0001 << grant_id_q;
            tx_en_q <= 1'b0;
            state_q <= SEND;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
            tx_en_q       <= 1'b0;
            state_q       <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
`endif
        end
        SEND: begin
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign arb_busy = (state_q != IDLE);
  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model plus directed scenarios.
module tb_uart_tx_arbiter;
  localparam int TO     = 8;
  localparam int XDELAY = 3;
  localparam int XLEN   = 4;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_50m = 1'b0;
  logic        clear;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;
  int xmode    = 0;   // 0: auto transmitter, 1: busy forced high, 2: busy stuck low

  logic [7:0] sent_q[$];
  int         ackid_q[$];

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_50m    (clk_50m),
    .clear      (clear),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy),
    .timeout_err(timeout_err)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] a);
    for (int i = 0; i < 4; i++)
      if (a[i]) return i;
    return -1;
  endfunction

  // Transmitter: once it sees tx_en, raises busy XDELAY cycles later for XLEN cycles.
  initial begin
    int  cnt;
    bit  act;
    cnt = 0;
    act = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk_50m);
      #1;
      if (xmode == 1) begin
        tx_busy = 1'b1; act = 1'b0;
      end else if (xmode == 2) begin
        tx_busy = 1'b0; act = 1'b0;
      end else if (!act) begin
        tx_busy = 1'b0;
        if (tx_en === 1'b1) begin act = 1'b1; cnt = 1; end
      end else begin
        cnt++;
        if (cnt == XDELAY) tx_busy = 1'b1;
        if (cnt == XDELAY + XLEN) begin tx_busy = 1'b0; act = 1'b0; end
      end
    end
  end

  // Model: phase 0 idle, 1 offering a byte, 2 transmitter busy with it.
  int         m_phase, m_last, m_gid, m_start_cycles;
  logic [7:0] m_byte;
  bit         m_en, m_to, m_valid = 1'b0;
  logic [3:0] m_ack;

  always @(posedge clk_50m) begin
    m_ack = 4'd0;
    m_to  = 1'b0;
    if (clear) begin
      m_valid = 1'b1; m_phase = 0; m_last = 3; m_gid = 0;
      m_byte = 8'h00; m_en = 1'b0; m_start_cycles = 0;
    end else if (m_valid) begin
      if (m_phase == 0) begin
        if (req != 4'd0 && !tx_busy) begin
          m_gid = rr_pick(m_last, req);
          m_last = m_gid;
          m_byte = req_data[8*m_gid +: 8];
          m_en = 1'b1; m_phase = 1; m_start_cycles = 0;
        end
      end else if (m_phase == 1) begin
        if (tx_busy) begin
          m_ack[m_gid] = 1'b1; m_en = 1'b0; m_phase = 2;
        end else begin
          m_start_cycles++;
          if (TO_EN && m_start_cycles == TO) begin
            m_to = 1'b1; m_en = 1'b0; m_phase = 0;
          end
        end
      end else if (!tx_busy) begin
        m_phase = 0;
      end
    end
  end

  always @(posedge clk_50m) begin
    #1;
    if (m_valid) begin
      chk("tx_en", {31'd0, tx_en}, {31'd0, m_en});
      chk("tx_data", {24'd0, tx_data}, {24'd0, m_byte});
      chk("ack", {28'd0, ack}, {28'd0, m_ack});
      chk("grant_id", {30'd0, grant_id}, 32'(m_gid));
      chk("arb_busy", {31'd0, arb_busy}, {31'd0, (m_phase != 0)});
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_to});
      chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
      if (ack != 4'd0) begin
        sent_q.push_back(tx_data);
        ackid_q.push_back(onehot_idx(ack));
      end
    end
  end

  task automatic wait_ack(input logic [3:0] drop_mask, output int idx);
    idx = -1;
    for (int n = 0; n < 300 && idx < 0; n++) begin
      @(negedge clk_50m);
      if (ack != 4'd0) begin
        idx = onehot_idx(ack);
        req = req & ~drop_mask;
      end
    end
    if (idx < 0) chk("ack_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk_50m);
      if (!arb_busy && !tx_busy) done = 1'b1;
    end
    if (!done) chk("idle_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int id, n0;
    bit seen;
    int cyc;
    logic [7:0] exp_bytes [5];
    int         exp_ids   [5];
    exp_bytes = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    exp_ids   = '{0, 1, 2, 3, 0};

    clear = 1'b1; req = 4'd0; req_data = 32'd0;
    repeat (3) @(negedge clk_50m);
    chk("rst_tx_en", {31'd0, tx_en}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_arb_busy", {31'd0, arb_busy}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    clear = 1'b0;

    // Single byte from requester 0
    req_data[7:0] = 8'hA5; req = 4'b0001;
    @(posedge clk_50m); #1;
    chk("s1_latency_tx_en", {31'd0, tx_en}, 32'd1);
    chk("s1_tx_data", {24'd0, tx_data}, 32'hA5);
    wait_ack(4'b0001, id);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk_50m); #2;
      if (!tx_busy) seen = 1'b1;
    end
    chk("s1_busy_still_high", {31'd0, arb_busy}, 32'd1);
    @(posedge clk_50m); #1;
    chk("s1_busy_fell", {31'd0, arb_busy}, 32'd0);
    wait_idle();
    chk("s1_ack_count", 32'(sent_q.size()), 32'd1);
    chk("s1_byte", {24'd0, sent_q[0]}, 32'hA5);
    chk("s1_ack_id", 32'(ackid_q[0]), 32'd0);

    // All four requesting continuously after a fresh clear
    @(negedge clk_50m); clear = 1'b1;
    @(negedge clk_50m); clear = 1'b0;
    n0 = sent_q.size();
    req_data = 32'h43322110; req = 4'b1111;
    for (int k = 0; k < 4; k++) wait_ack(4'b0000, id);
    wait_ack(4'b1111, id);
    wait_idle();
    chk("s2_ack_count", 32'(sent_q.size() - n0), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk("s2_byte", {24'd0, sent_q[n0 + k]}, {24'd0, exp_bytes[k]});
      chk("s2_ack_id", 32'(ackid_q[n0 + k]), 32'(exp_ids[k]));
    end

    // Data changed after grant must not affect the byte sent
    req_data[23:16] = 8'h3C; req = 4'b0100;
    @(posedge clk_50m);
    @(negedge clk_50m); req_data[23:16] = 8'hFF;
    wait_ack(4'b0100, id);
    wait_idle();
    chk("s3_byte", {24'd0, sent_q[sent_q.size() - 1]}, 32'h3C);
    chk("s3_ack_id", 32'(ackid_q[ackid_q.size() - 1]), 32'd2);

    // Clear during SEND with requester 1 still pending
    req_data[15:8] = 8'h5A; req = 4'b0010;
    wait_ack(4'b0000, id);
    clear = 1'b1;
    @(posedge clk_50m); #1;
    chk("s4_tx_en", {31'd0, tx_en}, 32'd0);
    chk("s4_tx_data", {24'd0, tx_data}, 32'd0);
    chk("s4_grant_id", {30'd0, grant_id}, 32'd0);
    chk("s4_arb_busy", {31'd0, arb_busy}, 32'd0);
    chk("s4_ack", {28'd0, ack}, 32'd0);
    @(negedge clk_50m); clear = 1'b0;
    n0 = sent_q.size();
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk_50m);
      if (arb_busy) seen = 1'b1;
    end
    chk("s4_regrant_seen", {31'd0, seen}, 32'd1);
    chk("s4_regrant_id", {30'd0, grant_id}, 32'd1);
    wait_ack(4'b0010, id);
    wait_idle();
    chk("s4_single_ack", 32'(sent_q.size() - n0), 32'd1);

    // Transmitter busy when requester 3 arrives
    xmode = 1; req_data[31:24] = 8'h77; req = 4'b1000;
    repeat (4) @(negedge clk_50m);
    chk("s5_no_tx_en", {31'd0, tx_en}, 32'd0);
    xmode = 0;
    #2;
    chk("s5_busy_fell", {31'd0, tx_busy}, 32'd0);
    chk("s5_still_idle", {31'd0, tx_en}, 32'd0);
    @(posedge clk_50m); #1;
    chk("s5_tx_en", {31'd0, tx_en}, 32'd1);
    chk("s5_grant_id", {30'd0, grant_id}, 32'd3);
    wait_ack(4'b1000, id);
    wait_idle();

`ifdef UART_ARB_TIMEOUT_EN
    // Stuck transmitter: abort after TO cycles, then requester 1 wins
    @(negedge clk_50m); clear = 1'b1;
    @(negedge clk_50m); clear = 1'b0;
    n0 = sent_q.size();
    xmode = 2; req = 4'b0001;
    @(posedge clk_50m); #1;
    chk("s6_tx_en", {31'd0, tx_en}, 32'd1);
    cyc = 0; seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk_50m); #1;
      cyc++;
      if (timeout_err) seen = 1'b1;
    end
    chk("s6_timeout_cycles", 32'(cyc), 32'd8);
    @(negedge clk_50m); req = 4'b0011; xmode = 0;
    @(posedge clk_50m); #1;
    chk("s6_next_winner", {30'd0, grant_id}, 32'd1);
    wait_ack(4'b0011, id);
    wait_idle();
    chk("s6_ack_count", 32'(sent_q.size() - n0), 32'd1);
    chk("s6_ack_id", 32'(ackid_q[ackid_q.size() - 1]), 32'd1);
`else
    // Stuck transmitter: START waits indefinitely, no timeout pulse
    xmode = 2; req_data[7:0] = 8'hC3; req = 4'b0001;
    repeat (30) @(negedge clk_50m);
    chk("s6_still_start", {31'd0, tx_en}, 32'd1);
    chk("s6_no_timeout", {31'd0, timeout_err}, 32'd0);
    xmode = 0;
    wait_ack(4'b0001, id);
    wait_idle();
    chk("s6_ack_id", 32'(ackid_q[ackid_q.size() - 1]), 32'd0);
    chk("s6_byte", {24'd0, sent_q[sent_q.size() - 1]}, 32'hC3);
`endif

    repeat (3) @(negedge clk_50m);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
